multdiv_ctrl: RTL and testbench

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

---
 rtl/multdiv_ctrl.sv | 122 ++++++++++++
 tb/tb_multdiv_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// Sequencing controller for an iterative 32-step multiply/divide datapath.
// It latches the operands, steps the datapath, and stalls the pipeline until the result is ready.
//
// state | meaning
// IDLE  | waiting for start_mult/start_div
// LOAD  | operands latched, datapath load pulse
// RUN   | 32 iteration cycles, step_cnt 0..31
// DONE  | result_rdy pulse, optional div_by_zero; can chain a new start
module multdiv_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] reg_a,
    input  logic [31:0] reg_b,
    input  logic [16:0] imm17,
    input  logic        imm_sel,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        dp_load,
    output logic        dp_step,
    output logic        dp_is_div,
    output logic [4:0]  step_cnt,
    output logic        stall,
    output logic        result_rdy,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        start_any;
    logic        accept;
    logic        op_b_zero;
    logic [31:0] op_b_sel;

    assign start_any = start_mult | start_div;
    assign op_b_zero = (op_b == 32'd0);
    assign op_b_sel  = imm_sel ? {{15{imm17[16]}}, imm17} : reg_b;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        dp_load     = 1'b0;
        dp_step     = 1'b0;
        result_rdy  = 1'b0;
        div_by_zero = 1'b0;
        stall       = 1'b0;
        case (state)
            IDLE: begin
                if (start_any) begin
                    accept    = 1'b1;
                    stall     = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                dp_load   = 1'b1;
                stall     = 1'b1;
                state_nxt = (dp_is_div && op_b_zero) ? DONE : RUN;
            end
            RUN: begin
                dp_step = 1'b1;
                stall   = 1'b1;
                if (step_cnt == 5'd31) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                result_rdy  = 1'b1;
                div_by_zero = dp_is_div & op_b_zero;
                state_nxt   = IDLE;
                if (start_any) begin
                    accept    = 1'b1;
                    stall     = 1'b1;
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // The start-driven stall path is combinational, so it must be masked while in reset.
        if (!reset) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            dp_is_div <= 1'b0;
            step_cnt  <= 5'd0;
        end else begin
            if (accept) begin
                op_a      <= reg_a;
                op_b      <= op_b_sel;
                dp_is_div <= start_div & ~start_mult;
            end
            // step_cnt wraps from 31 to 0 naturally on the last RUN cycle.
            if (state == LOAD) begin
                step_cnt <= 5'd0;
            end else if (state == RUN) begin
                step_cnt <= step_cnt + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed testbench for multdiv_ctrl: a vector table of whole operations, plus
// cycle-accurate sequences for timing, collisions, back-to-back starts and mid-operation reset.
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] reg_a = 32'd0;
    logic [31:0] reg_b = 32'd0;
    logic [16:0] imm17 = 17'd0;
    logic        imm_sel = 1'b0;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        dp_load;
    logic        dp_step;
    logic        dp_is_div;
    logic [4:0]  step_cnt;
    logic        stall;
    logic        result_rdy;
    logic        div_by_zero;

    int total = 0;
    int bad = 0;

    multdiv_ctrl dut (
        .clock(clock), .reset(reset),
        .start_mult(start_mult), .start_div(start_div),
        .reg_a(reg_a), .reg_b(reg_b), .imm17(imm17), .imm_sel(imm_sel),
        .op_a(op_a), .op_b(op_b),
        .dp_load(dp_load), .dp_step(dp_step), .dp_is_div(dp_is_div),
        .step_cnt(step_cnt), .stall(stall),
        .result_rdy(result_rdy), .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [16:0] imm;
        logic        sel;
        logic [31:0] exp_b;
        logic        exp_div;
        logic        exp_dbz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // After this returns we are 1 time unit past a rising edge.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Called in cycle 1 (LOAD) of an operation; runs until result_rdy and checks latency.
    task automatic run_to_done(input string nm, input int exp_lat, input logic exp_dbz,
                               input logic [31:0] exp_b);
        int  cyc;
        bit  seen;
        cyc  = 1;
        seen = 0;
        while (cyc < 60 && !seen) begin
            if (result_rdy) begin
                seen = 1;
                chk({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
                chk({nm, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
                chk({nm, "_op_b_hold"}, op_b, exp_b);
                chk({nm, "_stall_done"}, 32'(stall), 32'(start_mult | start_div));
            end else begin
                tick;
                cyc++;
            end
        end
        if (!seen) chk({nm, "_result_seen"}, 32'd0, 32'd1);
    endtask

    task automatic do_vec(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        reg_a = v.a; reg_b = v.b; imm17 = v.imm; imm_sel = v.sel;
        start_mult = v.m; start_div = v.d;
        #1;
        chk({nm, "_stall_start"}, 32'(stall), 32'd1);
        tick;
        start_mult = 1'b0; start_div = 1'b0;
        reg_a = ~v.a; reg_b = ~v.b; imm17 = ~v.imm; imm_sel = ~v.sel;
        #1;
        chk({nm, "_dp_load"}, 32'(dp_load), 32'd1);
        chk({nm, "_op_a"}, op_a, v.a);
        chk({nm, "_op_b"}, op_b, v.exp_b);
        chk({nm, "_is_div"}, 32'(dp_is_div), 32'(v.exp_div));
        run_to_done(nm, v.exp_lat, v.exp_dbz, v.exp_b);
        tick;
        chk({nm, "_idle_after"}, {29'd0, dp_load, dp_step, result_rdy}, 32'd0);
        chk({nm, "_dbz_after"}, 32'(div_by_zero), 32'd0);
    endtask

    initial begin
        int  cyc;
        int  guard;
        bit  hit;

        vecs[0] = '{1'b1, 1'b0, 32'd7,         32'd5,         17'h00000, 1'b0, 32'h00000005, 1'b0, 1'b0, 34};
        vecs[1] = '{1'b0, 1'b1, 32'h11111111,  32'd0,         17'h10000, 1'b1, 32'hFFFF0000, 1'b1, 1'b0, 34};
        vecs[2] = '{1'b0, 1'b1, 32'h22222222,  32'd0,         17'h0FFFF, 1'b1, 32'h0000FFFF, 1'b1, 1'b0, 34};
        vecs[3] = '{1'b0, 1'b1, 32'd100,       32'd0,         17'h00001, 1'b0, 32'h00000000, 1'b1, 1'b1, 2};
        vecs[4] = '{1'b1, 1'b1, 32'd9,         32'd0,         17'h00000, 1'b0, 32'h00000000, 1'b0, 1'b0, 34};
        vecs[5] = '{1'b1, 1'b0, 32'hCAFEF00D,  32'd77,        17'h00000, 1'b1, 32'h00000000, 1'b0, 1'b0, 34};
        vecs[6] = '{1'b0, 1'b1, 32'd5,         32'd0,         17'h00001, 1'b1, 32'h00000001, 1'b1, 1'b0, 34};
        vecs[7] = '{1'b0, 1'b1, 32'd5,         32'd3,         17'h00000, 1'b1, 32'h00000000, 1'b1, 1'b1, 2};

        // Reset state with a start request held: everything must stay 0.
        start_mult = 1'b1; start_div = 1'b1;
        reg_a = 32'hFFFFFFFF; reg_b = 32'hFFFFFFFF;
        tick; tick;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_pulses", {29'd0, dp_load, dp_step, result_rdy}, 32'd0);
        chk("rst_op_a", op_a, 32'd0);
        chk("rst_op_b", op_b, 32'd0);
        chk("rst_misc", {26'd0, step_cnt, dp_is_div}, 32'd0);
        start_mult = 1'b0; start_div = 1'b0;
        reset = 1'b1;
        tick;
        chk("idle_stall", 32'(stall), 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_vec(vecs[i], i);
        end

        // Cycle-by-cycle multiply with a stray start_div in cycle 10, then a chained start in DONE.
        reg_a = 32'd7; reg_b = 32'd5; imm_sel = 1'b0; start_mult = 1'b1;
        #1;
        chk("seq_c0_stall", 32'(stall), 32'd1);
        chk("seq_c0_rdy", 32'(result_rdy), 32'd0);
        for (int c = 1; c <= 33; c++) begin
            tick;
            start_mult = 1'b0;
            start_div = (c == 10);
            reg_a = 32'd1000 + 32'(c); reg_b = 32'd0;
            #1;
            chk($sformatf("seq_c%0d_stall", c), 32'(stall), 32'd1);
            chk($sformatf("seq_c%0d_load", c), 32'(dp_load), 32'(c == 1));
            chk($sformatf("seq_c%0d_step", c), 32'(dp_step), 32'(c >= 2));
            chk($sformatf("seq_c%0d_rdy", c), 32'(result_rdy), 32'd0);
            if (c >= 2) chk($sformatf("seq_c%0d_cnt", c), 32'(step_cnt), 32'(c - 2));
            chk($sformatf("seq_c%0d_opb", c), op_b, 32'd5);
            chk($sformatf("seq_c%0d_isdiv", c), 32'(dp_is_div), 32'd0);
        end
        tick;
        start_div = 1'b0;
        reg_a = 32'd3; reg_b = 32'd9; start_mult = 1'b1;
        #1;
        chk("seq_c34_rdy", 32'(result_rdy), 32'd1);
        chk("seq_c34_dbz", 32'(div_by_zero), 32'd0);
        chk("seq_c34_step", 32'(dp_step), 32'd0);
        chk("seq_c34_cnt", 32'(step_cnt), 32'd0);
        chk("seq_c34_stall", 32'(stall), 32'd1);
        tick;
        start_mult = 1'b0;
        #1;
        chk("b2b_load", 32'(dp_load), 32'd1);
        chk("b2b_op_a", op_a, 32'd3);
        chk("b2b_op_b", op_b, 32'd9);
        run_to_done("b2b", 34, 1'b0, 32'd9);
        tick;

        // Divide-by-zero timing, then reset mid-operation.
        reg_a = 32'h55; reg_b = 32'd0; start_div = 1'b1;
        tick;
        start_div = 1'b0;
        #1;
        chk("dz_c1_load", 32'(dp_load), 32'd1);
        tick;
        chk("dz_c2_rdy", {30'd0, result_rdy, div_by_zero}, 32'd3);
        chk("dz_c2_step", 32'(dp_step), 32'd0);
        tick;
        chk("dz_c3_idle", {28'd0, dp_load, dp_step, result_rdy, stall}, 32'd0);

        reg_a = 32'h55; reg_b = 32'd4; start_div = 1'b1;
        tick;
        start_div = 1'b0;
        hit = 0;
        guard = 0;
        while (!hit && guard < 40) begin
            if (dp_step && step_cnt == 5'd15) hit = 1;
            else begin tick; guard++; end
        end
        chk("mid_reached15", 32'(hit), 32'd1);
        chk("mid_isdiv_pre", 32'(dp_is_div), 32'd1);
        #2;
        reset = 1'b0;
        start_mult = 1'b1;
        #1;
        chk("mid_async_pulses", {29'd0, dp_load, dp_step, result_rdy}, 32'd0);
        chk("mid_async_stall", 32'(stall), 32'd0);
        chk("mid_async_op_a", op_a, 32'd0);
        chk("mid_async_op_b", op_b, 32'd0);
        chk("mid_async_misc", {25'd0, step_cnt, dp_is_div, div_by_zero}, 32'd0);
        for (int k = 0; k < 20; k++) begin
            tick;
            chk($sformatf("mid_rst_k%0d", k), {28'd0, dp_load, dp_step, result_rdy, stall}, 32'd0);
        end
        start_mult = 1'b0;
        reset = 1'b1;
        tick;
        chk("post_rst_idle", {28'd0, dp_load, dp_step, result_rdy, stall}, 32'd0);
        reg_a = 32'd2; reg_b = 32'd3; start_mult = 1'b1;
        tick;
        start_mult = 1'b0;
        #1;
        chk("post_rst_load", 32'(dp_load), 32'd1);
        run_to_done("post_rst", 34, 1'b0, 32'd3);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
